cmd_credit_tag_alloc: RTL and testbench
=======================================

CMD_CREDIT_TAG_ALLOC -- requirements
Module: cmd_credit_tag_alloc

Interface
REQ-001 The block SHALL have parameter CREDITS_READ, default 32, giving the read-class command credits.
REQ-002 The block SHALL have parameter CREDITS_WRITE, default 32, giving the write-class command credits.
REQ-003 The block SHALL have parameter TAG_BITS, default 8, giving the tag width; usable tags are 1..CREDITS_READ+CREDITS_WRITE (64), and tag 0 is invalid.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-low, with ports named clock and rstn.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 enabled_in  in  1  allocation enable; when 0, both ready outputs are 0.
REQ-008 read_req_in  in  1  read command request.
REQ-009 read_ready_out  out  1  read request is accepted this cycle.
REQ-010 write_req_in  in  1  write command request.
REQ-011 write_ready_out  out  1  write request is accepted this cycle.
REQ-012 cmd_valid_out  out  1  registered grant pulse.
REQ-013 cmd_is_write_out  out  1  class of the granted command.
REQ-014 cmd_tag_out  out  TAG_BITS  tag of the granted command.
REQ-015 rsp_valid_in  in  1  PSL response strobe.
REQ-016 rsp_tag_in  in  TAG_BITS  tag of the response.
REQ-017 read_credits_out  out  6  available read credits.
REQ-018 write_credits_out  out  6  available write credits.
REQ-019 free_tags_out  out  7  count of free tags.
REQ-020 error_out  out  1  sticky flag for a response carrying an illegal tag.

Function
REQ-021 State SHALL consist of: a 64-bit outstanding bitmap, a 64-bit class bitmap (1 = write), two credit counters, a free-tag counter, the output registers and the error flag.
REQ-022 write_ready_out SHALL equal enabled_in AND write_credits>0 AND free_tags>0.
REQ-023 read_ready_out SHALL equal enabled_in AND read_credits>0 AND free_tags>0 AND NOT write_req_in.
REQ-024 As a consequence of REQ-022/REQ-023, when both requests are present, write wins; at most one grant occurs per cycle.
REQ-025 A grant SHALL occur when a request and its matching ready are both high in the same cycle.
REQ-026 On a grant, the allocated tag SHALL be the lowest-numbered free tag, taken from the pre-update bitmap.
REQ-027 On a grant, the block SHALL set the outstanding bit for that tag, record its class, and decrement the matching credit counter and free_tags.
REQ-028 The cycle after a grant, cmd_valid_out SHALL be 1 for exactly one cycle, with cmd_tag_out and cmd_is_write_out valid (latency 1).
REQ-029 When there is no grant, cmd_valid_out SHALL be 0; cmd_tag_out and cmd_is_write_out SHALL hold their last values.
REQ-030 A response with rsp_valid_in=1 and an outstanding, nonzero rsp_tag_in SHALL clear that tag's outstanding bit, increment free_tags, and increment the credit counter of the recorded class.
REQ-031 A response with tag 0, a tag greater than 64, or a tag that is not outstanding SHALL change no state except setting error_out=1.
REQ-032 error_out SHALL remain 1 until reset.
REQ-033 When a grant and a response happen in the same cycle, both updates SHALL apply.
REQ-034 A same-class grant and response in the same cycle SHALL leave the credit count net unchanged, and SHALL leave free_tags unchanged.
REQ-035 A tag freed in cycle N SHALL NOT be allocatable until cycle N+1.
REQ-036 Credit counters SHALL never exceed their parameter value and SHALL never go below 0.
REQ-037 Counter arithmetic SHALL be unsigned, with no wrap-around.
REQ-038 free_tags SHALL always equal 64 minus the popcount of the outstanding bitmap.

Reset
REQ-039 While rstn=0, and asynchronously on its assertion, the block SHALL force: cmd_valid_out=0, cmd_tag_out=0, cmd_is_write_out=0, read_credits_out=32, write_credits_out=32, free_tags_out=64, error_out=0, both bitmaps all zero.
REQ-040 Reset asserted mid-operation SHALL discard all outstanding tags; responses to those tags after reset release SHALL set error_out.
REQ-041 The first grant after reset release SHALL occur no earlier than the first rising clock edge with rstn=1.

Verification
REQ-042 Reset release, then read_req_in=1 held for 33 cycles with enabled_in=1 -> tags 1..32 issued in order, read_ready_out=0 on the 33rd cycle, read_credits_out=0, free_tags_out=32.
REQ-043 read_req_in=1 and write_req_in=1 in the same cycle from reset -> write granted with tag 1, cmd_is_write_out=1 one cycle later; read granted tag 2 the following cycle.
REQ-044 Tags 1-3 outstanding, rsp on tag 2 -> next grant receives tag 2; the credit of tag 2's class is restored.
REQ-045 Grant (read) and response (read tag 5) in the same cycle -> read_credits_out unchanged, free_tags_out unchanged, tag 5 not reissued that cycle.
REQ-046 rsp_valid_in with tag 0, then with a non-outstanding tag 40 -> error_out=1; counters unchanged.
REQ-047 10 tags outstanding, rstn pulsed low mid-cycle -> outputs return to reset values immediately; a later response on tag 3 -> error_out=1.

Source files
------------

// File: rtl/cmd_credit_tag_alloc_if.sv
// Command/response bus between a requester and the credit/tag allocator.
// The allocator sits on the slave side; the requester drives the master side.
interface cmd_credit_tag_alloc_if #(
  parameter int TAG_BITS = 8
);
  // request side
  logic                enabled_in;
  logic                read_req_in;
  logic                read_ready_out;
  logic                write_req_in;
  logic                write_ready_out;
  // registered grant
  logic                cmd_valid_out;
  logic                cmd_is_write_out;
  logic [TAG_BITS-1:0] cmd_tag_out;
  // response side
  logic                rsp_valid_in;
  logic [TAG_BITS-1:0] rsp_tag_in;
  // status
  logic [5:0]          read_credits_out;
  logic [5:0]          write_credits_out;
  logic [6:0]          free_tags_out;
  logic                error_out;

  modport slave (
    input  enabled_in, read_req_in, write_req_in, rsp_valid_in, rsp_tag_in,
    output read_ready_out, write_ready_out, cmd_valid_out, cmd_is_write_out,
           cmd_tag_out, read_credits_out, write_credits_out, free_tags_out,
           error_out
  );

  modport master (
    output enabled_in, read_req_in, write_req_in, rsp_valid_in, rsp_tag_in,
    input  read_ready_out, write_ready_out, cmd_valid_out, cmd_is_write_out,
           cmd_tag_out, read_credits_out, write_credits_out, free_tags_out,
           error_out
  );
endinterface

// File: rtl/cmd_credit_tag_alloc.sv
// Credit-based command tag allocator.
// Read and write commands each consume a class credit and one tag; a response
// returns the tag and the credit of the class recorded at grant time. Tags are
// 1..CREDITS_READ+CREDITS_WRITE, tag 0 is never issued. The lowest free tag
// is always handed out, chosen from the bitmap as it stood before this cycle's
// updates, so a tag released this cycle cannot be re-issued in the same cycle.
module cmd_credit_tag_alloc #(
  parameter int CREDITS_READ  = 32,
  parameter int CREDITS_WRITE = 32,
  parameter int TAG_BITS      = 8
) (
  input  logic                  clock,
  input  logic                  rstn,
  cmd_credit_tag_alloc_if.slave bus
);

  localparam int NTAGS       = CREDITS_READ + CREDITS_WRITE;
  localparam int IDX_BITS    = $clog2(NTAGS);
  localparam int CREDIT_BITS = 6;
  localparam int FREE_BITS   = 7;

  localparam logic [CREDIT_BITS-1:0] READ_INIT  = CREDIT_BITS'(CREDITS_READ);
  localparam logic [CREDIT_BITS-1:0] WRITE_INIT = CREDIT_BITS'(CREDITS_WRITE);
  localparam logic [FREE_BITS-1:0]   FREE_INIT  = FREE_BITS'(NTAGS);

  // state
  logic [NTAGS-1:0]       outstanding_reg, outstanding_next;
  logic [NTAGS-1:0]       class_reg, class_next;
  logic [CREDIT_BITS-1:0] read_credits_reg, read_credits_next;
  logic [CREDIT_BITS-1:0] write_credits_reg, write_credits_next;
  logic [FREE_BITS-1:0]   free_tags_reg, free_tags_next;
  logic                   cmd_valid_reg;
  logic                   cmd_is_write_reg;
  logic [TAG_BITS-1:0]    cmd_tag_reg;
  logic                   error_reg;

  // handshake
  logic read_ready;
  logic write_ready;
  logic grant_read;
  logic grant_write;
  logic grant;

  // allocation
  logic [IDX_BITS-1:0] alloc_idx;
  logic                alloc_found;
  logic [TAG_BITS-1:0] alloc_tag;

  // response decode
  logic                rsp_in_range;
  logic [IDX_BITS-1:0] rsp_idx;
  logic                rsp_release;
  logic                rsp_is_write;
  logic                rsp_error;

  // Write has priority: read is only ready when no write is being requested.
  assign write_ready = bus.enabled_in && (write_credits_reg != '0) && (free_tags_reg != '0);
  assign read_ready  = bus.enabled_in && (read_credits_reg != '0) && (free_tags_reg != '0)
                       && !bus.write_req_in;

  assign grant_write = bus.write_req_in && write_ready;
  assign grant_read  = bus.read_req_in && read_ready;
  assign grant       = grant_write || grant_read;

  // Lowest-numbered free tag from the pre-update bitmap; scan high to low so
  // the last hit is the lowest index.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!outstanding_reg[i]) begin
        alloc_idx   = IDX_BITS'(i);
        alloc_found = 1'b1;
      end
    end
  end

  assign alloc_tag = TAG_BITS'(alloc_idx) + TAG_BITS'(1);

  // A response is legal only for a nonzero, in-range tag that is outstanding.
  assign rsp_in_range = (bus.rsp_tag_in != '0) &&
                        ({{(32-TAG_BITS){1'b0}}, bus.rsp_tag_in} <= 32'(NTAGS));
  assign rsp_idx      = IDX_BITS'(bus.rsp_tag_in - TAG_BITS'(1));
  assign rsp_release  = bus.rsp_valid_in && rsp_in_range && outstanding_reg[rsp_idx];
  assign rsp_is_write = class_reg[rsp_idx];
  assign rsp_error    = bus.rsp_valid_in && !rsp_release;

  // Per-tag bitmap update: a grant sets its bit and records the class, a legal
  // response clears its bit. The two never target the same tag in one cycle.
  generate
    for (genvar gi = 0; gi < NTAGS; gi++) begin : g_tag
      logic set_bit;
      logic clr_bit;
      assign set_bit = grant && alloc_found && (alloc_idx == IDX_BITS'(gi));
      assign clr_bit = rsp_release && (rsp_idx == IDX_BITS'(gi));
      assign outstanding_next[gi] = (outstanding_reg[gi] || set_bit) && !clr_bit;
      assign class_next[gi]       = set_bit ? grant_write : class_reg[gi];
    end
  endgenerate

  // Counter updates; grant and release of the same class cancel out.
  always_comb begin
    read_credits_next  = read_credits_reg;
    write_credits_next = write_credits_reg;
    free_tags_next     = free_tags_reg;
    if (grant_read) begin
      read_credits_next = read_credits_next - CREDIT_BITS'(1);
    end
    if (grant_write) begin
      write_credits_next = write_credits_next - CREDIT_BITS'(1);
    end
    if (rsp_release && !rsp_is_write) begin
      read_credits_next = read_credits_next + CREDIT_BITS'(1);
    end
    if (rsp_release && rsp_is_write) begin
      write_credits_next = write_credits_next + CREDIT_BITS'(1);
    end
    if (grant && !rsp_release) begin
      free_tags_next = free_tags_reg - FREE_BITS'(1);
    end else if (rsp_release && !grant) begin
      free_tags_next = free_tags_reg + FREE_BITS'(1);
    end
  end

  // Bitmaps and counters.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      outstanding_reg   <= '0;
      class_reg         <= '0;
      read_credits_reg  <= READ_INIT;
      write_credits_reg <= WRITE_INIT;
      free_tags_reg     <= FREE_INIT;
    end else begin
      outstanding_reg   <= outstanding_next;
      class_reg         <= class_next;
      read_credits_reg  <= read_credits_next;
      write_credits_reg <= write_credits_next;
      free_tags_reg     <= free_tags_next;
    end
  end

  // Registered grant: one-cycle valid pulse, tag and class hold between grants.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_reg    <= 1'b0;
      cmd_is_write_reg <= 1'b0;
      cmd_tag_reg      <= '0;
    end else begin
      cmd_valid_reg <= grant;
      if (grant) begin
        cmd_is_write_reg <= grant_write;
        cmd_tag_reg      <= alloc_tag;
      end
    end
  end

  // Sticky illegal-response flag.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      error_reg <= 1'b0;
    end else if (rsp_error) begin
      error_reg <= 1'b1;
    end
  end

  assign bus.read_ready_out    = read_ready;
  assign bus.write_ready_out   = write_ready;
  assign bus.cmd_valid_out     = cmd_valid_reg;
  assign bus.cmd_is_write_out  = cmd_is_write_reg;
  assign bus.cmd_tag_out       = cmd_tag_reg;
  assign bus.read_credits_out  = read_credits_reg;
  assign bus.write_credits_out = write_credits_reg;
  assign bus.free_tags_out     = free_tags_reg;
  assign bus.error_out         = error_reg;

endmodule

// File: tb/tb_cmd_credit_tag_alloc.sv
// Directed bench for cmd_credit_tag_alloc with hand-computed expectations.
module tb_cmd_credit_tag_alloc;

  logic clock;
  logic rstn;
  int   assertions;
  int   failures;

  cmd_credit_tag_alloc_if #(.TAG_BITS(8)) bus ();

  cmd_credit_tag_alloc #(
    .CREDITS_READ (32),
    .CREDITS_WRITE(32),
    .TAG_BITS     (8)
  ) dut (
    .clock(clock),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end else begin
      $display("ok   %s: %0d", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string ctx);
    check({ctx, ".cmd_valid"},     32'(bus.cmd_valid_out),     32'd0);
    check({ctx, ".cmd_tag"},       32'(bus.cmd_tag_out),       32'd0);
    check({ctx, ".cmd_is_write"},  32'(bus.cmd_is_write_out),  32'd0);
    check({ctx, ".read_credits"},  32'(bus.read_credits_out),  32'd32);
    check({ctx, ".write_credits"}, 32'(bus.write_credits_out), 32'd32);
    check({ctx, ".free_tags"},     32'(bus.free_tags_out),     32'd64);
    check({ctx, ".error"},         32'(bus.error_out),         32'd0);
  endtask

  // Assert reset mid-cycle, check it takes effect at once, release after an edge.
  task automatic pulse_reset(input string ctx);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values({ctx, ".async"});
    tick();
    rstn = 1'b1;
  endtask

  task automatic check_grant(input string ctx, input int tag, input int is_write);
    check({ctx, ".valid"},    32'(bus.cmd_valid_out),    32'd1);
    check({ctx, ".tag"},      32'(bus.cmd_tag_out),      32'(tag));
    check({ctx, ".is_write"}, 32'(bus.cmd_is_write_out), 32'(is_write));
  endtask

  task automatic check_counts(input string ctx, input int rc, input int wc, input int ft);
    check({ctx, ".read_credits"},  32'(bus.read_credits_out),  32'(rc));
    check({ctx, ".write_credits"}, 32'(bus.write_credits_out), 32'(wc));
    check({ctx, ".free_tags"},     32'(bus.free_tags_out),     32'(ft));
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rstn = 1'b0;
    bus.enabled_in   = 1'b0;
    bus.read_req_in  = 1'b0;
    bus.write_req_in = 1'b0;
    bus.rsp_valid_in = 1'b0;
    bus.rsp_tag_in   = '0;

    repeat (3) tick();
    check_reset_values("reset");
    @(negedge clock);
    rstn = 1'b1;

    // Enable low blocks both readies.
    bus.write_req_in = 1'b1;
    bus.read_req_in  = 1'b1;
    #1;
    check("disabled.write_ready", 32'(bus.write_ready_out), 32'd0);
    check("disabled.read_ready",  32'(bus.read_ready_out),  32'd0);
    tick();
    check("disabled.cmd_valid", 32'(bus.cmd_valid_out), 32'd0);
    check_counts("disabled", 32, 32, 64);
    bus.write_req_in = 1'b0;

    // Read credit exhaustion: tags 1..32 in order, then no ready.
    bus.enabled_in = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      #1;
      check($sformatf("rd_fill%0d.ready", i), 32'(bus.read_ready_out), (i <= 32) ? 32'd1 : 32'd0);
      tick();
      if (i <= 32) begin
        check_grant($sformatf("rd_fill%0d", i), i, 0);
      end
    end
    check("rd_fill.end_valid", 32'(bus.cmd_valid_out), 32'd0);
    check("rd_fill.end_tag_hold", 32'(bus.cmd_tag_out), 32'd32);
    check_counts("rd_fill.end", 0, 32, 32);
    bus.read_req_in = 1'b0;
    tick();
    pulse_reset("rst1");

    // Simultaneous requests: write wins with tag 1, read follows with tag 2.
    bus.read_req_in  = 1'b1;
    bus.write_req_in = 1'b1;
    #1;
    check("both.write_ready", 32'(bus.write_ready_out), 32'd1);
    check("both.read_ready",  32'(bus.read_ready_out),  32'd0);
    tick();
    check_grant("both.w", 1, 1);
    check_counts("both.w", 32, 31, 63);
    bus.write_req_in = 1'b0;
    #1;
    check("both.read_ready2", 32'(bus.read_ready_out), 32'd1);
    tick();
    check_grant("both.r", 2, 0);
    check_counts("both.r", 31, 31, 62);
    tick();
    check_grant("t3", 3, 0);
    check_counts("t3", 30, 31, 61);

    // Release tag 2, it is the next tag issued.
    bus.read_req_in  = 1'b0;
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd2;
    tick();
    bus.rsp_valid_in = 1'b0;
    check("rel2.valid", 32'(bus.cmd_valid_out), 32'd0);
    check("rel2.tag_hold", 32'(bus.cmd_tag_out), 32'd3);
    check_counts("rel2", 31, 31, 62);
    bus.read_req_in = 1'b1;
    tick();
    check_grant("reuse2", 2, 0);
    check_counts("reuse2", 30, 31, 61);
    tick();
    check_grant("t4", 4, 0);
    tick();
    check_grant("t5", 5, 0);
    check_counts("t5", 28, 31, 59);

    // Same-cycle read grant and read-tag-5 release.
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd5;
    tick();
    bus.rsp_valid_in = 1'b0;
    check_grant("same", 6, 0);
    check_counts("same", 28, 31, 59);
    tick();
    check_grant("after_same", 5, 0);
    check_counts("after_same", 27, 31, 58);
    bus.read_req_in = 1'b0;

    // Release write tag 1 restores write credit.
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd1;
    tick();
    check_counts("rel1", 27, 32, 59);
    check("rel1.error", 32'(bus.error_out), 32'd0);

    // Illegal responses.
    bus.rsp_tag_in = 8'd0;
    tick();
    bus.rsp_valid_in = 1'b0;
    check("tag0.error", 32'(bus.error_out), 32'd1);
    check_counts("tag0", 27, 32, 59);
    repeat (2) tick();
    check("tag0.sticky", 32'(bus.error_out), 32'd1);
    pulse_reset("rst2");
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd40;
    tick();
    bus.rsp_valid_in = 1'b0;
    check("tag40.error", 32'(bus.error_out), 32'd1);
    check_counts("tag40", 32, 32, 64);
    pulse_reset("rst3");
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd65;
    tick();
    bus.rsp_valid_in = 1'b0;
    check("tag65.error", 32'(bus.error_out), 32'd1);
    check_counts("tag65", 32, 32, 64);
    pulse_reset("rst4");

    // Ten reads outstanding, reset mid-cycle, stale response flags an error.
    bus.read_req_in = 1'b1;
    repeat (10) tick();
    bus.read_req_in = 1'b0;
    check_grant("ten", 10, 0);
    check_counts("ten", 22, 32, 54);
    pulse_reset("rst5");
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 8'd3;
    tick();
    bus.rsp_valid_in = 1'b0;
    check("stale3.error", 32'(bus.error_out), 32'd1);
    check_counts("stale3", 32, 32, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
